// File: rtl/spi_regs_pkg.sv
// Shared definitions for the two-byte SPI register-access frame.
// Used by the peripheral instruction decoder and by the host-side encoder
// (instr_enc): read/write bit values, setup-byte field positions, the list of
// 16-bit register base addresses and the encoder's state enum.
package spi_regs_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned ADDR_W         = 6;
  localparam int unsigned SETUP_RW_BIT   = 7;
  localparam int unsigned SETUP_HI_BIT   = 6;
  localparam int unsigned SETUP_ADDR_MSB = 5;
  localparam int unsigned SETUP_ADDR_LSB = 0;

  localparam int unsigned NUM_REG16 = 4;
  localparam logic [ADDR_W-1:0] REG16_ADDRS [NUM_REG16] = '{6'h00, 6'h03, 6'h05, 6'h08};

  function automatic logic is_16b_reg(input logic [ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REG16; i++) begin
      if (REG16_ADDRS[i] == addr) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [7:0] setup_byte(input logic rw, input logic hi,
                                            input logic [ADDR_W-1:0] addr);
    logic [7:0] b;
    b = '0;
    b[SETUP_RW_BIT] = rw;
    b[SETUP_HI_BIT] = hi;
    b[SETUP_ADDR_MSB:SETUP_ADDR_LSB] = addr;
    return b;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_SETUP,
    ST_WAIT_SETUP,
    ST_SEND_DATA,
    ST_WAIT_DATA,
    ST_RESP
  } enc_state_t;

endpackage

// File: rtl/instr_enc.sv
// instr_enc: host-side initiator of SPI register-access frames.
// Turns 8/16-bit register read/write requests into setup+data byte pairs for
// an SPI master byte engine, reassembles pipelined MISO read data and returns
// one response per request. Reads end with a flush frame to FLUSH_ADDR that
// fetches the last read byte.
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/ready/write/wide/addr/wdata   request handshake and fields
//   rsp_valid/ready/rdata/err               response handshake and fields
//   tx_valid/ready/byte      byte to the SPI master (registered, held until taken)
//   rx_valid/byte            exchange-complete pulse and the MISO byte
//   busy                     high whenever not idle
module instr_enc
  import spi_regs_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FLUSH_ADDR = 6'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_wide,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_byte,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              busy
);

  enc_state_t        state_q, state_n;
  logic              wr_q, wr_n;
  logic              wide_q, wide_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [15:0]       wdata_q, wdata_n;
  logic              k_q, k_n;
  logic              rd_pend_q, rd_pend_n;
  logic              flush_q, flush_n;
  logic [15:0]       rdata_q, rdata_n;
  logic              err_q, err_n;
  logic              tx_valid_q, tx_valid_n;
  logic [7:0]        tx_byte_q, tx_byte_n;
  logic              sel_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_q       <= 1'b0;
      wide_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      k_q        <= 1'b0;
      rd_pend_q  <= 1'b0;
      flush_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      state_q    <= state_n;
      wr_q       <= wr_n;
      wide_q     <= wide_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      k_q        <= k_n;
      rd_pend_q  <= rd_pend_n;
      flush_q    <= flush_n;
      rdata_q    <= rdata_n;
      err_q      <= err_n;
      tx_valid_q <= tx_valid_n;
      tx_byte_q  <= tx_byte_n;
    end
  end

  // tx_valid/tx_byte are registered, so they are loaded on the transition
  // into SEND_* rather than decoded from the current state.
  always_comb begin
    state_n    = state_q;
    wr_n       = wr_q;
    wide_n     = wide_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    k_n        = k_q;
    rd_pend_n  = rd_pend_q;
    flush_n    = flush_q;
    rdata_n    = rdata_q;
    err_n      = err_q;
    tx_valid_n = tx_valid_q;
    tx_byte_n  = tx_byte_q;
    // Read data arrives one frame late; the flush frame carries the last one.
    sel_hi     = flush_q ? k_q : (k_q - 1'b1);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_n      = req_write;
          wide_n    = req_wide;
          addr_n    = req_addr;
          wdata_n   = req_wdata;
          k_n       = 1'b0;
          rd_pend_n = 1'b0;
          flush_n   = 1'b0;
          rdata_n   = '0;
          err_n     = 1'b0;
          if (req_wide && !is_16b_reg(req_addr)) begin
            err_n   = 1'b1;
            state_n = ST_RESP;
          end else begin
            state_n    = ST_SEND_SETUP;
            tx_valid_n = 1'b1;
            tx_byte_n  = setup_byte(req_write, 1'b0, req_addr);
          end
        end
      end
      ST_SEND_SETUP: begin
        if (tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = ST_WAIT_SETUP;
        end
      end
      ST_WAIT_SETUP: begin
        if (rx_valid) begin
          if (rd_pend_q) begin
            if (sel_hi) rdata_n[15:8] = rx_byte;
            else        rdata_n[7:0]  = rx_byte;
          end
          state_n    = ST_SEND_DATA;
          tx_valid_n = 1'b1;
          if (!flush_q && wr_q == RW_WRITE) tx_byte_n = k_q ? wdata_q[15:8] : wdata_q[7:0];
          else                             tx_byte_n = '0;
        end
      end
      ST_SEND_DATA: begin
        if (tx_ready) begin
          tx_valid_n = 1'b0;
          state_n    = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (rx_valid) begin
          rd_pend_n = (wr_q == RW_READ) && !flush_q;
          if (wide_q && !k_q && !flush_q) begin
            k_n        = 1'b1;
            state_n    = ST_SEND_SETUP;
            tx_valid_n = 1'b1;
            tx_byte_n  = setup_byte(wr_q, 1'b1, addr_q);
          end else if (wr_q == RW_READ && !flush_q) begin
            flush_n    = 1'b1;
            state_n    = ST_SEND_SETUP;
            tx_valid_n = 1'b1;
            tx_byte_n  = setup_byte(RW_READ, 1'b0, FLUSH_ADDR);
          end else begin
            state_n = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
